ksz_bus_responder: RTL and testbench

- Synthesizable slave model of the Ethernet controller's 16-bit asynchronous host bus (CSN/CMD/RDN/WRN/SD).
- It is the responder end of the host-side register I/O initiator. It lets the init, transmit and receive sequencers be exercised on-board, or in simulation, without the real PHY/MAC chip.
- Contents: a 128-word register file, an RX data queue loaded from a local inject port, a TX capture stream, and interrupt generation.

---
 rtl/ksz_bus_responder.sv | 214 +++++++++++++++++++++
 tb/tb_ksz_bus_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ksz_bus_responder.sv
// rtl/ksz_bus_responder.sv - slave model of the 16-bit async host bus with register file, RX queue and TX capture
// Optional interrupt logic: define KSZ_RESPONDER_INTR_EN.
module ksz_bus_responder #(
   parameter int          FIFO_DEPTH    = 16,
   parameter logic [7:0]  DATA_OFFSET   = 8'hD8,
   parameter logic [7:0]  CHIPID_OFFSET = 8'hC0,
   parameter logic [15:0] CHIPID_VALUE  = 16'h8872,
   parameter logic [7:0]  ISR_OFFSET    = 8'h92,
   parameter logic [7:0]  IER_OFFSET    = 8'h90
) (
   input  logic                          sysclk,
   input  logic                          reset,
   input  logic                          CSN,
   input  logic                          CMD,
   input  logic                          RDN,
   input  logic                          WRN,
   inout  wire  [15:0]                   SD,
   output logic                          INTRN,
   input  logic [15:0]                   rx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   output logic [15:0]                   tx_data,
   output logic                          tx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          bus_error
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [6:0]    ISR_IDX  = ISR_OFFSET[7:1];
`ifdef KSZ_RESPONDER_INTR_EN
   localparam bit ISR_W1C = 1'b1;
`else
   localparam bit ISR_W1C = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CMD_WR, DATA_WR, DATA_RD} state_t;
   state_t state_q, state_d;

   logic [1:0]  csn_sync_q, cmd_sync_q, rdn_sync_q, wrn_sync_q;
   logic [15:0] sd_meta_q, sd_sync_q;
   logic        rdn_prev_q, wrn_prev_q;
   logic        csn_s, cmd_s, rdn_s, wrn_s;
   logic        rd_fall, rd_rise, wr_rise;

   logic [7:0]  addr_q;
   logic [1:0]  be_q;
   logic [15:0] be_mask;
   logic [15:0] wr_data_q, rd_word_q, rd_value;
   logic        rd_pop_q, oe_q;
   logic [15:0] tx_data_q;
   logic        tx_valid_q, bus_error_q;

   logic [15:0] regs_q [128];

   logic [15:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q;
   logic          fifo_empty, push, pop;

   // Two-flop synchronizers; edge detection runs on the second stage only.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         csn_sync_q <= 2'b11;
         cmd_sync_q <= 2'b00;
         rdn_sync_q <= 2'b11;
         wrn_sync_q <= 2'b11;
         sd_meta_q  <= '0;
         sd_sync_q  <= '0;
         rdn_prev_q <= 1'b1;
         wrn_prev_q <= 1'b1;
      end else begin
         csn_sync_q <= {csn_sync_q[0], CSN};
         cmd_sync_q <= {cmd_sync_q[0], CMD};
         rdn_sync_q <= {rdn_sync_q[0], RDN};
         wrn_sync_q <= {wrn_sync_q[0], WRN};
         sd_meta_q  <= SD;
         sd_sync_q  <= sd_meta_q;
         rdn_prev_q <= rdn_s;
         wrn_prev_q <= wrn_s;
      end
   end

   assign csn_s   = csn_sync_q[1];
   assign cmd_s   = cmd_sync_q[1];
   assign rdn_s   = rdn_sync_q[1];
   assign wrn_s   = wrn_sync_q[1];
   assign rd_fall = !csn_s && rdn_prev_q && !rdn_s;
   // Release is not gated by CSN so the driver can never be left on.
   assign rd_rise = rdn_s && !rdn_prev_q;
   assign wr_rise = !csn_s && rdn_s && rdn_prev_q && wrn_s && !wrn_prev_q;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rd_fall)      state_d = DATA_RD;
            else if (wr_rise) state_d = cmd_s ? CMD_WR : DATA_WR;
         end
         CMD_WR, DATA_WR: state_d = IDLE;
         DATA_RD: if (rd_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign fifo_empty = (level_q == '0);
   assign be_mask    = {{8{be_q[1]}}, {8{be_q[0]}}};

   always_comb begin
      rd_value = regs_q[addr_q[7:1]];
      if (cmd_s)                        rd_value = '0;
      else if (addr_q == DATA_OFFSET)   rd_value = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
      else if (addr_q == CHIPID_OFFSET) rd_value = CHIPID_VALUE;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         addr_q      <= '0;
         be_q        <= 2'b11;
         wr_data_q   <= '0;
         rd_word_q   <= '0;
         rd_pop_q    <= 1'b0;
         oe_q        <= 1'b0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         tx_valid_q  <= 1'b0;
         bus_error_q <= 1'b0;
         oe_q        <= (state_q == DATA_RD) && !rd_rise;
         if (state_q == IDLE && rd_fall) begin
            rd_word_q   <= rd_value;
            rd_pop_q    <= !cmd_s && (addr_q == DATA_OFFSET) && !fifo_empty;
            bus_error_q <= !cmd_s && (addr_q == DATA_OFFSET) && fifo_empty;
         end
         if (state_q == IDLE && wr_rise)
            wr_data_q <= sd_sync_q;
         if (state_q == CMD_WR) begin
            addr_q <= {wr_data_q[7:1], 1'b0};
            be_q   <= wr_data_q[13:12];
         end
         if (state_q == DATA_WR && addr_q == DATA_OFFSET) begin
            tx_data_q  <= wr_data_q;
            tx_valid_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) regs_q[i] <= '0;
      end else begin
         if (state_q == DATA_WR && addr_q != DATA_OFFSET && addr_q != CHIPID_OFFSET) begin
            if (ISR_W1C && addr_q == ISR_OFFSET)
               regs_q[ISR_IDX] <= regs_q[ISR_IDX] & ~(wr_data_q & be_mask);
            else
               regs_q[addr_q[7:1]] <= (regs_q[addr_q[7:1]] & ~be_mask) | (wr_data_q & be_mask);
         end
`ifdef KSZ_RESPONDER_INTR_EN
         // Placed after the host clear so a coincident push keeps bit 13 set.
         if (push) regs_q[ISR_IDX][13] <= 1'b1;
`endif
      end
   end

   assign push = rx_valid && rx_ready;
   assign pop  = (state_q == DATA_RD) && rd_rise && rd_pop_q && !fifo_empty;

   always_ff @(posedge sysclk) begin
      if (push) fifo_mem[wr_ptr_q] <= rx_data;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

`ifdef KSZ_RESPONDER_INTR_EN
   logic intrn_q;
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) intrn_q <= 1'b1;
      else       intrn_q <= ~|(regs_q[ISR_IDX] & regs_q[IER_OFFSET[7:1]]);
   end
   assign INTRN = intrn_q;
`else
   assign INTRN = 1'b1;
`endif

   assign SD        = oe_q ? rd_word_q : 16'hzzzz;
   assign rx_ready  = (level_q != LVL_FULL);
   assign rx_level  = level_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign bus_error = bus_error_q;

endmodule

// File: tb/tb_ksz_bus_responder.sv
// tb/tb_ksz_bus_responder.sv - directed bench for ksz_bus_responder
module tb_ksz_bus_responder;

   logic        sysclk = 1'b0;
   logic        reset;
   logic        CSN, CMD, RDN, WRN;
   tri1  [15:0] SD;
   logic        INTRN;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic [4:0]  rx_level;
   logic        bus_error;

   logic        host_oe;
   logic [15:0] host_d;
   logic [15:0] rd;
   logic [15:0] exp_w;
   int          n_err = 0;
   int          n_chk = 0;
   int          tx_cnt = 0;
   int          be_cnt = 0;
   logic [15:0] tx_last = '0;

   assign SD = host_oe ? host_d : 16'hzzzz;

   ksz_bus_responder dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .CSN       (CSN),
      .CMD       (CMD),
      .RDN       (RDN),
      .WRN       (WRN),
      .SD        (SD),
      .INTRN     (INTRN),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .rx_level  (rx_level),
      .bus_error (bus_error)
   );

   always #5 sysclk = ~sysclk;

   always @(negedge sysclk) begin
      if (tx_valid) begin
         tx_cnt  = tx_cnt + 1;
         tx_last = tx_data;
      end
      if (bus_error) be_cnt = be_cnt + 1;
   end

   task automatic cyc();
      @(posedge sysclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic cmd, input logic [15:0] d);
      CSN = 1'b0; CMD = cmd; host_d = d; host_oe = 1'b1;
      cyc();
      WRN = 1'b0;
      repeat (5) cyc();
      WRN = 1'b1;
      repeat (3) cyc();
      host_oe = 1'b0; CSN = 1'b1;
      repeat (3) cyc();
   endtask

   task automatic bus_read(input logic cmd, output logic [15:0] d);
      CSN = 1'b0; CMD = cmd;
      cyc();
      RDN = 1'b0;
      repeat (5) cyc();
      d = SD;
      RDN = 1'b1;
      repeat (3) cyc();
      CSN = 1'b1;
      repeat (2) cyc();
   endtask

   task automatic push_word(input logic [15:0] d);
      rx_data = d; rx_valid = 1'b1;
      cyc();
      rx_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; CSN = 1'b1; CMD = 1'b0; RDN = 1'b1; WRN = 1'b1;
      host_oe = 1'b0; host_d = '0; rx_data = '0; rx_valid = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      check("rst_sd", SD, 16'hFFFF);
      check("rst_intrn", INTRN, 1'b1);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 16'h0000);
      check("rst_bus_error", bus_error, 1'b0);
      check("rst_rx_level", rx_level, 5'd0);
      check("rst_rx_ready", rx_ready, 1'b1);

      // Chip ID read with drive/release timing
      bus_write(1'b1, 16'h30C0);
      CSN = 1'b0; CMD = 1'b0;
      cyc();
      RDN = 1'b0;
      repeat (4) cyc();
      check("chipid_driven", SD, 16'h8872);
      RDN = 1'b1;
      repeat (3) cyc();
      check("chipid_release", SD, 16'hFFFF);
      CSN = 1'b1;
      repeat (2) cyc();

      // Byte-enable write
      bus_write(1'b1, 16'h1010);
      bus_write(1'b0, 16'hABCD);
      bus_write(1'b1, 16'h3010);
      bus_read(1'b0, rd);
      check("be_low_only", rd, 16'h00CD);

      // Queue reads in order, then underflow
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      check("lvl_three", rx_level, 5'd3);
      bus_write(1'b1, 16'h30D8);
      bus_read(1'b0, rd); check("q_rd0", rd, 16'h1111);
      check("lvl_two", rx_level, 5'd2);
      bus_read(1'b0, rd); check("q_rd1", rd, 16'h2222);
      bus_read(1'b0, rd); check("q_rd2", rd, 16'h3333);
      check("lvl_zero", rx_level, 5'd0);
      bus_read(1'b0, rd); check("q_empty_rd", rd, 16'h0000);
      check("bus_error_once", be_cnt, 1);
      check("lvl_still_zero", rx_level, 5'd0);

      // Fill, overflow drop, coincident push/pop
      for (int i = 0; i < 16; i++) push_word(16'h0A00 + 16'(i));
      check("lvl_full", rx_level, 5'd16);
      check("ready_full", rx_ready, 1'b0);
      push_word(16'hDEAD);
      check("lvl_after_drop", rx_level, 5'd16);
      bus_read(1'b0, rd); check("full_rd0", rd, 16'h0A00);
      check("lvl_15", rx_level, 5'd15);
      CSN = 1'b0; CMD = 1'b0;
      cyc();
      RDN = 1'b0;
      repeat (5) cyc();
      rd = SD;
      RDN = 1'b1;
      cyc();
      cyc();
      check("lvl_before_pop", rx_level, 5'd15);
      rx_data = 16'hBBBB; rx_valid = 1'b1;
      cyc();
      rx_valid = 1'b0;
      check("lvl_pushpop", rx_level, 5'd15);
      check("pushpop_rd", rd, 16'h0A01);
      CSN = 1'b1;
      repeat (2) cyc();
      push_word(16'hCCCC);
      check("lvl_refill", rx_level, 5'd16);
      for (int i = 0; i < 16; i++) begin
         exp_w = (i < 14) ? 16'h0A02 + 16'(i) : ((i == 14) ? 16'hBBBB : 16'hCCCC);
         bus_read(1'b0, rd);
         check($sformatf("drain_%0d", i), rd, exp_w);
      end
      check("lvl_drained", rx_level, 5'd0);

      // TX capture and write-ignored addresses
      bus_write(1'b0, 16'hBEEF);
      check("tx_pulse_cnt", tx_cnt, 1);
      check("tx_data_val", tx_last, 16'hBEEF);
      bus_write(1'b1, 16'h3010);
      bus_read(1'b0, rd);
      check("reg10_intact", rd, 16'h00CD);
      bus_write(1'b1, 16'h30C0);
      bus_write(1'b0, 16'h1234);
      bus_read(1'b0, rd);
      check("chipid_ro", rd, 16'h8872);
      bus_read(1'b1, rd);
      check("cmd_read_zero", rd, 16'h0000);

`ifdef KSZ_RESPONDER_INTR_EN
      bus_write(1'b1, 16'h3090);
      bus_write(1'b0, 16'h2000);
      check("intrn_idle", INTRN, 1'b1);
      push_word(16'h5555);
      repeat (2) cyc();
      check("intrn_set", INTRN, 1'b0);
      bus_write(1'b1, 16'h3092);
      bus_write(1'b0, 16'h2000);
      check("intrn_cleared", INTRN, 1'b1);
      push_word(16'h6666);
      repeat (2) cyc();
      check("intrn_set2", INTRN, 1'b0);
      CSN = 1'b0; CMD = 1'b0; host_d = 16'h2000; host_oe = 1'b1;
      cyc();
      WRN = 1'b0;
      repeat (5) cyc();
      WRN = 1'b1;
      repeat (3) cyc();
      rx_data = 16'h7777; rx_valid = 1'b1;
      cyc();
      rx_valid = 1'b0; host_oe = 1'b0; CSN = 1'b1;
      repeat (3) cyc();
      check("intrn_set_wins", INTRN, 1'b0);
      bus_read(1'b0, rd);
      check("isr_bit13", rd, 16'h2000);
`else
      bus_write(1'b1, 16'h3092);
      bus_write(1'b0, 16'h2000);
      bus_read(1'b0, rd);
      check("isr_plain_rw", rd, 16'h2000);
      push_word(16'h5555);
      repeat (2) cyc();
      check("intrn_tied", INTRN, 1'b1);
`endif

      // Reset in the middle of a read
      push_word(16'h4444);
      bus_write(1'b1, 16'h30C0);
      CSN = 1'b0; CMD = 1'b0;
      cyc();
      RDN = 1'b0;
      repeat (5) cyc();
      check("midrd_driven", SD, 16'h8872);
      reset = 1'b1;
      #1;
      check("midrd_release", SD, 16'hFFFF);
      check("midrd_flush", rx_level, 5'd0);
      check("midrd_ready", rx_ready, 1'b1);
      cyc();
      reset = 1'b0; RDN = 1'b1; CSN = 1'b1;
      repeat (4) cyc();
      check("post_rst_sd", SD, 16'hFFFF);
      check("post_rst_lvl", rx_level, 5'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
